dense_layer_seq: RTL

Parametrised single dense layer computing y[j] = act(sum_i W[j][i]*x[i] + b[j]) in signed fixed point, time-multiplexed on one multiply-accumulate unit. Successor to the fixed-size net core: generic widths and layer sizes, on-chip writable weight/bias store, and selectable activation. Instances are chained with start/done to build multi-layer networks.

---
 rtl/nn_pkg.sv | 40 ++++
 rtl/nn_activation.sv | 46 ++++
 rtl/dense_layer_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: activation codes,
// sequencer state encoding and the accumulator-to-data-width saturation helper.
package nn_pkg;

  localparam logic [1:0] ACT_ID   = 2'd0;
  localparam logic [1:0] ACT_RELU = 2'd1;
  localparam logic [1:0] ACT_HSIG = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2
  } state_e;

  // Working widths of sat_q; callers sign-extend into / slice out of these.
  localparam int SAT_ACC_W = 128;
  localparam int SAT_DW    = 64;

  function automatic logic signed [SAT_DW-1:0] sat_q(
    input logic signed [SAT_ACC_W-1:0] acc,
    input int                          dw,
    input int                          frac
  );
    logic signed [SAT_ACC_W-1:0] v;
    logic signed [SAT_ACC_W-1:0] hi;
    logic signed [SAT_ACC_W-1:0] lo;
    logic signed [SAT_ACC_W-1:0] one;
    one = SAT_ACC_W'(1);
    v   = acc >>> frac;
    hi  = (one <<< (dw - 1)) - one;
    lo  = -hi - one;
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v[SAT_DW-1:0];
  endfunction

endpackage

// File: rtl/nn_activation.sv
// Combinational rescale, saturate and activation of a wide fixed-point
// accumulator down to a DW-bit result.
module nn_activation
  import nn_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 34
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [1:0]       mode_i,
  output logic signed [DW-1:0]    y_o
);

  localparam logic signed [DW+1:0] HALF = (DW+2)'(1) << (FRAC - 1);
  localparam logic signed [DW+1:0] ONE  = (DW+2)'(1) << FRAC;

  logic signed [SAT_ACC_W-1:0] acc_ext;
  logic signed [SAT_DW-1:0]    sat_full;
  logic signed [DW-1:0]        v;
  logic signed [DW+1:0]        v_ext;
  logic signed [DW+1:0]        hs;

  assign acc_ext  = {{(SAT_ACC_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign sat_full = sat_q(acc_ext, DW, FRAC);
  assign v        = sat_full[DW-1:0];
  // Two guard bits keep the hard-sigmoid offset from wrapping before the clamp.
  assign v_ext    = {{2{v[DW-1]}}, v};

  always_comb begin
    hs = (v_ext >>> 2) + HALF;
    if (hs[DW+1]) begin
      hs = '0;
    end else if (hs > ONE) begin
      hs = ONE;
    end

    y_o = v;
    case (mode_i)
      ACT_RELU: y_o = v[DW-1] ? '0 : v;
      ACT_HSIG: y_o = hs[DW-1:0];
      default:  y_o = v;
    endcase
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Single dense layer y[j] = act(sum_i W[j][i]*x[i] + b[j]) on one shared MAC,
// with a writable weight/bias store and start/done handshake for chaining.
module dense_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DW*N_IN-1:0]    x,
  input  logic [1:0]            act_mode,
  input  logic                  w_we,
  input  logic [AW-1:0]         w_addr,
  input  logic [DW-1:0]         w_data,
  output logic [DW*N_OUT-1:0]   y,
  output logic                  busy,
  output logic                  done
);

  localparam int             DEPTH   = N_OUT*(N_IN+1);
  localparam int             ACC_W   = 2*DW + $clog2(N_IN+1);
  localparam int             IW      = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int             JW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);

  logic signed [DW-1:0] mem [DEPTH];

  state_e                     state_q, state_d;
  logic [IW-1:0]              i_q, i_d;
  logic [JW-1:0]              j_q, j_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [N_IN-1:0][DW-1:0]    x_q, x_d;
  logic [1:0]                 mode_q, mode_d;
  logic [N_OUT-1:0][DW-1:0]   y_q, y_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic [AW:0]                rd_addr;
  logic signed [DW-1:0]       rd_data;
  logic signed [2*DW-1:0]     prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_acc;
  logic signed [DW-1:0]       act_y;

  // ptr_q walks the store row-major; in ACT it sits on b[j], so b[j+1] is one row ahead.
  always_comb begin
    case (state_q)
      ST_MAC:  rd_addr = {1'b0, ptr_q};
      ST_ACT:  rd_addr = {1'b0, ptr_q} + (AW+1)'(N_IN+1);
      default: rd_addr = (AW+1)'(N_IN);
    endcase
    rd_data = (rd_addr < DEPTH_L) ? mem[rd_addr[AW-1:0]] : '0;
  end

  assign prod     = rd_data * $signed(x_q[i_q]);
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign bias_acc = {{(ACC_W-DW-FRAC){rd_data[DW-1]}}, rd_data, {FRAC{1'b0}}};

  nn_activation #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_act (
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .y_o    (act_y)
  );

  always_ff @(posedge clk) begin
    if (w_we && (state_q == ST_IDLE) && ({1'b0, w_addr} < DEPTH_L)) begin
      mem[w_addr] <= w_data;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    x_d     = x_q;
    mode_d  = mode_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MAC;
          x_d     = x;
          mode_d  = act_mode;
          i_d     = '0;
          j_d     = '0;
          ptr_d   = '0;
          acc_d   = bias_acc;
          busy_d  = 1'b1;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + prod_ext;
        i_d   = i_q + 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (i_q == IW'(N_IN-1)) begin
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        y_d[j_q] = act_y;
        acc_d    = bias_acc;
        ptr_d    = ptr_q + 1'b1;
        i_d      = '0;
        if (j_q == JW'(N_OUT-1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      mode_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_y
    assign y[DW*gi +: DW] = y_q[gi];
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
